// File: rtl/punc_datapath_mc.sv
// Multicycle PUnC LC3 datapath: PC/IR/MAR/MDR, NZP, register file, offset network,
// ALU, address adder, and a req/ack memory transaction FSM driven by external strobes.
module punc_datapath_mc #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 16,
  parameter int                NUM_REGS = 8,
  parameter logic [ADDR_W-1:0] PC_RESET = '0,
  localparam int               RA_W     = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_ld,
  input  logic              pc_inc,
  input  logic [1:0]        pc_src,
  input  logic              ir_ld,
  input  logic [1:0]        off_sel,
  input  logic              addr_base_sel,
  input  logic [RA_W-1:0]   rf_r0_addr,
  input  logic [RA_W-1:0]   rf_r1_addr,
  input  logic [RA_W-1:0]   rf_w_addr,
  input  logic              rf_w_en,
  input  logic [1:0]        rf_w_src,
  input  logic [1:0]        alu_op,
  input  logic              alu_b_sel,
  input  logic              cc_ld,
  input  logic              cc_src,
  input  logic              mar_ld,
  input  logic [1:0]        mar_src,
  input  logic              mem_start,
  input  logic              mem_write,
  output logic              mem_busy,
  output logic              mem_done,
  output logic [DATA_W-1:0] ir,
  output logic [2:0]        nzp,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  input  logic [RA_W-1:0]   rf_debug_addr,
  output logic [DATA_W-1:0] rf_debug_data,
  output logic [ADDR_W-1:0] pc_debug_data
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} mem_state_t;

  mem_state_t state, state_nxt;

  logic [ADDR_W-1:0] pc, mar;
  logic [DATA_W-1:0] ir_q, mdr, wdata_q;
  logic              we_q;
  logic [2:0]        nzp_q;
  logic [DATA_W-1:0] rf [NUM_REGS];

  logic signed [DATA_W-1:0] off, rd0, rd1, alu_b, alu_y, rf_wd, cc_val;
  logic [ADDR_W-1:0]        addr_base, addr_sum, pc_off;
  logic                     busy, mdr_cap;

  function automatic logic signed [DATA_W-1:0] sext_off(input logic [DATA_W-1:0] v,
                                                        input logic [1:0]        sel);
    logic signed [DATA_W-1:0] r;
    case (sel)
      2'd0:    r = DATA_W'($signed(v[8:0]));
      2'd1:    r = DATA_W'($signed(v[10:0]));
      2'd2:    r = DATA_W'($signed(v[5:0]));
      default: r = DATA_W'($signed(v[4:0]));
    endcase
    return r;
  endfunction

  function automatic logic [2:0] cc_flags(input logic signed [DATA_W-1:0] v);
    if (v < 0)       return 3'b100;
    else if (v == 0) return 3'b010;
    else             return 3'b001;
  endfunction

  function automatic logic [DATA_W-1:0] zext_addr(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] r;
    r = '0;
    r[ADDR_W-1:0] = a;
    return r;
  endfunction

  assign off       = sext_off(ir_q, off_sel);
  assign rd0       = rf[rf_r0_addr];
  assign rd1       = rf[rf_r1_addr];
  assign alu_b     = alu_b_sel ? off : rd1;
  assign addr_base = addr_base_sel ? rd0[ADDR_W-1:0] : pc;
  assign addr_sum  = addr_base + off[ADDR_W-1:0];
  assign pc_off    = pc + off[ADDR_W-1:0];

  always_comb begin
    alu_y = rd0;
    case (alu_op)
      2'd0:    alu_y = rd0 + alu_b;
      2'd1:    alu_y = rd0 & alu_b;
      2'd2:    alu_y = ~rd0;
      default: alu_y = rd0;
    endcase
  end

  always_comb begin
    rf_wd = alu_y;
    case (rf_w_src)
      2'd0:    rf_wd = alu_y;
      2'd1:    rf_wd = mdr;
      2'd2:    rf_wd = zext_addr(pc);
      default: rf_wd = zext_addr(addr_sum);
    endcase
  end

  assign cc_val = cc_src ? rf_wd : alu_y;

  // Architectural state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= PC_RESET;
      ir_q  <= '0;
      nzp_q <= 3'b010;
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else begin
      if (pc_ld) begin
        case (pc_src)
          2'd0:    pc <= pc_off;
          2'd1:    pc <= rd0[ADDR_W-1:0];
          2'd2:    pc <= alu_y[ADDR_W-1:0];
          default: pc <= pc;
        endcase
      end else if (pc_inc) begin
        pc <= pc + ADDR_W'(1);
      end
      if (ir_ld)   ir_q <= mdr;
      if (cc_ld)   nzp_q <= cc_flags(cc_val);
      if (rf_w_en) rf[rf_w_addr] <= rf_wd;
    end
  end

  // Memory interface registers; MAR is frozen while a transaction is in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mar     <= '0;
      mdr     <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      if (mar_ld && !busy) begin
        case (mar_src)
          2'd0:    mar <= pc;
          2'd1:    mar <= addr_sum;
          2'd2:    mar <= mdr[ADDR_W-1:0];
          default: mar <= mar;
        endcase
      end
      if (mdr_cap) mdr <= mem_rdata;
      if (state == IDLE && mem_start) begin
        we_q    <= mem_write;
        wdata_q <= rd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_done  = 1'b0;
    case (state)
      IDLE: if (mem_start) state_nxt = REQ;
      REQ: begin
        mem_req = 1'b1;
        mem_we  = we_q;
        if (mem_ack) state_nxt = DONE;
      end
      DONE: begin
        mem_done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy          = (state != IDLE);
  assign mdr_cap       = (state == REQ) && mem_ack && !we_q;
  assign mem_busy      = busy;
  assign mem_addr      = mar;
  assign mem_wdata     = wdata_q;
  assign ir            = ir_q;
  assign nzp           = nzp_q;
  assign rf_debug_data = rf[rf_debug_addr];
  assign pc_debug_data = pc;

endmodule

// File: tb/tb_punc_datapath_mc.sv
// Scoreboarded bench for punc_datapath_mc: directed scenarios plus randomized control
// vectors against a plain-arithmetic model of the datapath and a responding memory.
module tb_punc_datapath_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_ld, pc_inc, ir_ld, addr_base_sel, rf_w_en, alu_b_sel;
  logic        cc_ld, cc_src, mar_ld, mem_start, mem_write;
  logic [1:0]  pc_src, off_sel, rf_w_src, alu_op, mar_src;
  logic [2:0]  rf_r0_addr, rf_r1_addr, rf_w_addr, rf_debug_addr;
  logic        mem_busy, mem_done, mem_req, mem_we, mem_ack;
  logic [15:0] ir, mem_addr, mem_wdata, mem_rdata, rf_debug_data, pc_debug_data;
  logic [2:0]  nzp;
  logic        resp_ack = 1'b0;
  logic        spurious_ack = 1'b0;
  logic [15:0] resp_rdata = 16'h0;

  assign mem_ack   = resp_ack | spurious_ack;
  assign mem_rdata = resp_rdata;

  punc_datapath_mc #(.DATA_W(16), .ADDR_W(16), .NUM_REGS(8), .PC_RESET(16'h3000)) dut (
    .clk(clk), .rst(rst), .pc_ld(pc_ld), .pc_inc(pc_inc), .pc_src(pc_src), .ir_ld(ir_ld),
    .off_sel(off_sel), .addr_base_sel(addr_base_sel), .rf_r0_addr(rf_r0_addr),
    .rf_r1_addr(rf_r1_addr), .rf_w_addr(rf_w_addr), .rf_w_en(rf_w_en), .rf_w_src(rf_w_src),
    .alu_op(alu_op), .alu_b_sel(alu_b_sel), .cc_ld(cc_ld), .cc_src(cc_src), .mar_ld(mar_ld),
    .mar_src(mar_src), .mem_start(mem_start), .mem_write(mem_write), .mem_busy(mem_busy),
    .mem_done(mem_done), .ir(ir), .nzp(nzp), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .rf_debug_addr(rf_debug_addr), .rf_debug_data(rf_debug_data), .pc_debug_data(pc_debug_data)
  );

  initial forever #10 clk = ~clk;

  typedef struct packed {
    logic       pc_ld, pc_inc;
    logic [1:0] pc_src;
    logic       ir_ld;
    logic [1:0] off_sel;
    logic       abs;
    logic [2:0] r0, r1, w;
    logic       w_en;
    logic [1:0] w_src, alu_op;
    logic       alu_b_sel, cc_ld, cc_src, mar_ld;
    logic [1:0] mar_src;
  } ctrl_t;

  typedef struct { bit we; int addr; int wdata; int lat; } exp_t;

  exp_t        sb[$];
  logic [15:0] mem [int];
  int          resp_lat = 1;
  int          errors = 0;
  int          checks = 0;
  int          m_pc, m_ir, m_mar, m_mdr, m_nzp;
  int          m_regs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mem_rd(input int a);
    if (mem.exists(a)) return mem[a];
    return 16'(a * 37 + 11);
  endfunction

  // Reference model: each field is reasoned about as plain integers
  function automatic int m_sext(input int irv, input int sel);
    int bits, f;
    case (sel)
      0:       bits = 9;
      1:       bits = 11;
      2:       bits = 6;
      default: bits = 5;
    endcase
    f = irv % (1 << bits);
    if (f >= (1 << (bits - 1))) f -= (1 << bits);
    return f;
  endfunction

  function automatic void model_reset();
    m_pc = 'h3000; m_ir = 0; m_mar = 0; m_mdr = 0; m_nzp = 2;
    for (int i = 0; i < 8; i++) m_regs[i] = 0;
  endfunction

  function automatic void model_step(input ctrl_t c);
    int sx, a, b, y, base, ad, wd, cv, npc, nmar, nir, nnzp;
    sx = m_sext(m_ir, int'(c.off_sel));
    a  = m_regs[c.r0];
    b  = c.alu_b_sel ? (sx & 'hFFFF) : m_regs[c.r1];
    case (c.alu_op)
      2'd0:    y = (a + b) % 65536;
      2'd1:    y = a & b;
      2'd2:    y = 65535 - a;
      default: y = a;
    endcase
    base = c.abs ? a : m_pc;
    ad   = (base + sx + 65536) % 65536;
    case (c.w_src)
      2'd0:    wd = y;
      2'd1:    wd = m_mdr;
      2'd2:    wd = m_pc;
      default: wd = ad;
    endcase
    cv   = c.cc_src ? wd : y;
    nnzp = m_nzp;
    if (c.cc_ld) nnzp = (cv >= 32768) ? 4 : ((cv == 0) ? 2 : 1);
    npc = m_pc;
    if (c.pc_ld) begin
      case (c.pc_src)
        2'd0:    npc = (m_pc + sx + 65536) % 65536;
        2'd1:    npc = a;
        2'd2:    npc = y;
        default: npc = m_pc;
      endcase
    end else if (c.pc_inc) npc = (m_pc + 1) % 65536;
    nmar = m_mar;
    if (c.mar_ld) begin
      case (c.mar_src)
        2'd0:    nmar = m_pc;
        2'd1:    nmar = ad;
        2'd2:    nmar = m_mdr;
        default: nmar = m_mar;
      endcase
    end
    nir = c.ir_ld ? m_mdr : m_ir;
    if (c.w_en) m_regs[c.w] = wd;
    m_pc = npc; m_mar = nmar; m_ir = nir; m_nzp = nnzp;
  endfunction

  task automatic idle_inputs();
    pc_ld = 0; pc_inc = 0; pc_src = 0; ir_ld = 0; off_sel = 0; addr_base_sel = 0;
    rf_r0_addr = 0; rf_r1_addr = 0; rf_w_addr = 0; rf_w_en = 0; rf_w_src = 0;
    alu_op = 0; alu_b_sel = 0; cc_ld = 0; cc_src = 0; mar_ld = 0; mar_src = 0;
    mem_start = 0; mem_write = 0;
  endtask

  task automatic step(input ctrl_t c);
    pc_ld = c.pc_ld; pc_inc = c.pc_inc; pc_src = c.pc_src; ir_ld = c.ir_ld;
    off_sel = c.off_sel; addr_base_sel = c.abs; rf_r0_addr = c.r0; rf_r1_addr = c.r1;
    rf_w_addr = c.w; rf_w_en = c.w_en; rf_w_src = c.w_src; alu_op = c.alu_op;
    alu_b_sel = c.alu_b_sel; cc_ld = c.cc_ld; cc_src = c.cc_src; mar_ld = c.mar_ld;
    mar_src = c.mar_src;
    @(posedge clk); #2;
    idle_inputs();
    model_step(c);
  endtask

  task automatic rf_read(input int r, output logic [15:0] v);
    rf_debug_addr = 3'(r);
    #1 v = rf_debug_data;
  endtask

  task automatic check_state(input string tag);
    logic [15:0] v;
    chk({tag, "_pc"}, 32'(pc_debug_data), m_pc);
    chk({tag, "_nzp"}, 32'(nzp), m_nzp);
    chk({tag, "_ir"}, 32'(ir), m_ir);
    for (int i = 0; i < 8; i++) begin
      rf_read(i, v);
      chk($sformatf("%s_r%0d", tag, i), 32'(v), m_regs[i]);
    end
  endtask

  task automatic mem_op(input bit we, input int lat, input int r1, input bit disturb,
                        input bit ir_at_ack);
    exp_t e;
    bit   seen;
    e.we = we; e.addr = m_mar; e.wdata = m_regs[r1]; e.lat = lat;
    sb.push_back(e);
    resp_lat   = lat;
    rf_r1_addr = 3'(r1);
    mem_start  = 1'b1;
    mem_write  = we;
    @(posedge clk); #2;
    idle_inputs();
    seen = 0;
    for (int c = 1; c <= lat + 6 && !seen; c++) begin
      if (disturb && c == 2) begin
        mem_start = 1; mem_write = 1; mar_ld = 1; mar_src = 2'd0; rf_r1_addr = 3'(r1 ^ 1);
      end
      if (ir_at_ack && c == lat) ir_ld = 1'b1;
      @(posedge clk); #2;
      idle_inputs();
      if (ir_at_ack && c == lat) m_ir = m_mdr;
      if (mem_done) begin
        seen = 1;
        chk("done_latency", 32'(c), 32'(lat));
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL mem_timeout: no mem_done within %0d cycles", lat + 6);
    end else if (!we) m_mdr = int'(mem_rd(e.addr));
    @(posedge clk); #2;
    chk("idle_after_done", 32'(mem_busy), 0);
  endtask

  task automatic load_reg(input int r, input int v);
    ctrl_t c;
    mem[m_pc] = 16'(v);
    c = '0; c.mar_ld = 1; c.mar_src = 2'd0;
    step(c);
    mem_op(0, 1 + int'($urandom_range(0, 2)), 0, 0, 0);
    c = '0; c.w_en = 1; c.w = 3'(r); c.w_src = 2'd1;
    step(c);
  endtask

  task automatic load_ir(input int v);
    ctrl_t c;
    mem[m_pc] = 16'(v);
    c = '0; c.mar_ld = 1; c.mar_src = 2'd0;
    step(c);
    mem_op(0, 2, 0, 0, 0);
    c = '0; c.ir_ld = 1;
    step(c);
  endtask

  // Memory responder: acks the resp_lat-th request cycle
  initial begin
    int cnt = 0;
    forever begin
      @(negedge clk);
      if (mem_req && !rst) begin
        cnt++;
        if (cnt == resp_lat) begin
          resp_ack = 1'b1;
          resp_rdata = mem_rd(int'(mem_addr));
          if (mem_we) mem[int'(mem_addr)] = mem_wdata;
        end
      end else begin
        resp_ack = 1'b0;
        cnt = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on every completed transaction
  initial begin
    exp_t        e;
    int          req_cnt = 0;
    bit          unstable = 0;
    logic [15:0] f_addr, f_wd;
    logic        f_we;
    forever begin
      @(negedge clk);
      if (rst) begin
        req_cnt = 0; unstable = 0;
      end else begin
        if (mem_req) begin
          if (req_cnt == 0) begin
            f_addr = mem_addr; f_wd = mem_wdata; f_we = mem_we;
          end else if (mem_addr !== f_addr || mem_wdata !== f_wd || mem_we !== f_we) unstable = 1;
          req_cnt++;
        end
        if (mem_done) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done: mem_done with no transaction outstanding");
          end else begin
            e = sb.pop_front();
            chk("sb_req_cycles", 32'(req_cnt), 32'(e.lat));
            chk("sb_addr", 32'(f_addr), 32'(e.addr));
            chk("sb_we", 32'(f_we), 32'(e.we));
            chk("sb_stable", 32'(unstable), 0);
            if (e.we) chk("sb_wdata", 32'(f_wd), 32'(e.wdata));
          end
          req_cnt = 0; unstable = 0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ctrl_t       c;
    logic [15:0] v;
    logic [31:0] rv;
    idle_inputs();
    rf_debug_addr = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_pc", 32'(pc_debug_data), 32'h3000);
    chk("rst_nzp", 32'(nzp), 32'b010);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_busy", 32'(mem_busy), 0);
    chk("rst_done", 32'(mem_done), 0);
    chk("rst_wdata", 32'(mem_wdata), 0);
    check_state("rst");

    // Fetch with three-cycle memory latency
    mem['h3000] = 16'h1261;
    c = '0; c.mar_ld = 1; c.mar_src = 2'd0; step(c);
    mem_op(0, 3, 0, 0, 0);
    c = '0; c.ir_ld = 1; step(c);
    chk("fetch_ir", 32'(ir), 32'h1261);

    // ADD R1, R1, #1
    load_reg(1, 5);
    c = '0; c.r0 = 1; c.alu_op = 0; c.alu_b_sel = 1; c.off_sel = 2'd3; c.w_en = 1; c.w = 1;
    c.cc_ld = 1; step(c);
    rf_read(1, v);
    chk("add_r1", 32'(v), 32'h6);
    chk("add_nzp", 32'(nzp), 32'b001);
    load_reg(1, 'h7FFF);
    step(c);
    rf_read(1, v);
    chk("add_wrap_r1", 32'(v), 32'h8000);
    chk("add_wrap_nzp", 32'(nzp), 32'b100);

    // IR load on the MDR capture edge takes the old MDR (7FFF)
    mem_op(0, 1, 0, 0, 1);
    chk("ir_old_mdr", 32'(ir), 32'h7FFF);
    check_state("post_add");

    // Store with disturbances during REQ
    load_reg(2, 'hABCD);
    load_reg(4, 'h4000);
    c = '0; c.mar_ld = 1; c.mar_src = 2'd2; step(c);
    mem_op(1, 4, 2, 1, 0);
    repeat (3) @(posedge clk);
    #2;
    chk("store_mem", 32'(mem_rd('h4000)), 32'hABCD);
    chk("store_single", 32'(sb.size()), 0);
    chk("store_idle", 32'(mem_busy), 0);

    // Ack while idle is ignored
    spurious_ack = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("spur_busy", 32'(mem_busy), 0);
    chk("spur_done", 32'(mem_done), 0);
    spurious_ack = 1'b0;

    // Branch, JMP with pc_inc, PC wrap
    load_reg(3, 'h3001);
    c = '0; c.pc_ld = 1; c.pc_src = 2'd1; c.r0 = 3; step(c);
    load_ir('h0FFE);
    c = '0; c.pc_ld = 1; c.pc_src = 2'd0; c.off_sel = 2'd0; step(c);
    chk("br_pc", 32'(pc_debug_data), 32'h2FFF);
    load_reg(3, 'h5000);
    c = '0; c.pc_ld = 1; c.pc_inc = 1; c.pc_src = 2'd1; c.r0 = 3; step(c);
    chk("jmp_pc", 32'(pc_debug_data), 32'h5000);
    load_reg(3, 'hFFFF);
    c = '0; c.pc_ld = 1; c.pc_src = 2'd1; c.r0 = 3; step(c);
    c = '0; c.pc_inc = 1; step(c);
    chk("pc_wrap", 32'(pc_debug_data), 32'h0000);
    check_state("post_branch");

    // Reset while a request is outstanding
    resp_lat = 1000;
    mem_start = 1'b1;
    @(posedge clk); #2;
    idle_inputs();
    @(posedge clk); #2;
    chk("abort_req_before", 32'(mem_req), 1);
    rst = 1'b1;
    #1;
    chk("abort_req_drop", 32'(mem_req), 0);
    chk("abort_busy", 32'(mem_busy), 0);
    model_reset();
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("abort_no_done", 32'(mem_done), 0);
    check_state("post_abort");
    mem_op(0, 1, 0, 0, 0);
    c = '0; c.ir_ld = 1; step(c);
    chk("fresh_ir", 32'(ir), 32'(mem_rd(0)));

    // Randomized control vectors and transactions
    for (int it = 0; it < 250; it++) begin
      int k;
      k = int'($urandom_range(0, 9));
      if (k < 5) begin
        rv = $urandom;
        c = rv[28:0];
        if (c.pc_src == 2'd3) c.pc_src = 2'd0;
        step(c);
      end else if (k < 7) begin
        load_reg(int'($urandom_range(0, 7)), int'($urandom_range(0, 65535)));
      end else if (k < 9) begin
        mem_op(0, int'($urandom_range(1, 4)), 0, 0, 1'($urandom_range(0, 1)));
      end else begin
        mem_op(1, int'($urandom_range(1, 4)), int'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)), 0);
      end
      check_state($sformatf("rnd%0d", it));
    end

    repeat (3) @(posedge clk);
    #2;
    chk("sb_drained", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
